multi_cycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS decoder.
- Holds an FSM that steps each instruction through fetch, decode, execute, memory and write-back.
- Uses valid/ready handshakes to instruction and data memory, and gates all datapath strobes by state.
- Adds a parametrised instruction-set mode and retire/cycle performance counters. Sits between the IR/memory interfaces and the multi-cycle datapath.

---
 rtl/multi_cycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: steps each instruction through fetch, decode,
// execute, memory and write-back with valid/ready handshakes to instruction and
// data memory, state-gated datapath strobes and cycle/retire counters.
module multi_cycle_control #(
   parameter int unsigned CNT_W   = 32,
   parameter bit          EXT_ISA = 1'b1   // 0: LUI/SLTI/SLTIU retire as NOP
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [5:0]       inst_31_26,
   input  logic [5:0]       inst_5_0,
   output logic             inst_req_valid,
   input  logic             inst_req_ready,
   input  logic             inst_valid,
   output logic             inst_ready,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   input  logic             mem_rdata_valid,
   output logic             mem_rdata_ready,
   output logic             ir_write,
   output logic             pc_inc,
   output logic             pc_write,
   output logic [2:0]       reg_dst,
   output logic [3:0]       branch,
   output logic [11:0]      alu_op,
   output logic [1:0]       alu_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [3:0]       write_strb,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] inst_cnt
);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpSlti  = 6'h0a;
   localparam logic [5:0] OpSltiu = 6'h0b;
   localparam logic [5:0] OpLui   = 6'h0f;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2b;

   localparam logic [5:0] FnSll   = 6'h00;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnAddu  = 6'h21;
   localparam logic [5:0] FnOr    = 6'h25;
   localparam logic [5:0] FnSlt   = 6'h2a;

   typedef enum logic [3:0] {
      StInit = 4'd0,
      StIf   = 4'd1,
      StIw   = 4'd2,
      StId   = 4'd3,
      StEx   = 4'd4,
      StMem  = 4'd5,
      StRdw  = 4'd6,
      StWb   = 4'd7
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cycle_q, inst_q;

   logic rtype;
   logic is_addiu, is_lw, is_sw, is_bne, is_beq, is_j, is_jal;
   logic is_lui, is_slti, is_sltiu;
   logic is_sll, is_addu, is_jr, is_or, is_slt;
   logic supported, dec_en, retire;

   // Instruction class decode from the opcode/funct fields.
   always_comb begin
      rtype     = (inst_31_26 == OpRtype);
      is_addiu  = (inst_31_26 == OpAddiu);
      is_lw     = (inst_31_26 == OpLw);
      is_sw     = (inst_31_26 == OpSw);
      is_bne    = (inst_31_26 == OpBne);
      is_beq    = (inst_31_26 == OpBeq);
      is_j      = (inst_31_26 == OpJ);
      is_jal    = (inst_31_26 == OpJal);
      is_lui    = EXT_ISA && (inst_31_26 == OpLui);
      is_slti   = EXT_ISA && (inst_31_26 == OpSlti);
      is_sltiu  = EXT_ISA && (inst_31_26 == OpSltiu);
      is_sll    = rtype && (inst_5_0 == FnSll);
      is_addu   = rtype && (inst_5_0 == FnAddu);
      is_jr     = rtype && (inst_5_0 == FnJr);
      is_or     = rtype && (inst_5_0 == FnOr);
      is_slt    = rtype && (inst_5_0 == FnSlt);
      supported = is_addiu | is_lw | is_sw | is_bne | is_beq | is_j | is_jal | is_lui |
                  is_slti | is_sltiu | is_sll | is_addu | is_jr | is_or | is_slt;
   end

   // IR contents are only meaningful once the word has been latched.
   assign dec_en = state_q inside {StId, StEx, StMem, StRdw, StWb};

   // Decode outputs, held at zero until the instruction register is valid.
   always_comb begin
      reg_dst    = '0;
      branch     = '0;
      alu_op     = '0;
      alu_src    = '0;
      mem_to_reg = 1'b0;
      if (dec_en) begin
         reg_dst[0]  = is_addiu | is_lw | is_lui | is_slti | is_sltiu;
         reg_dst[1]  = is_sll | is_addu | is_or | is_slt;
         reg_dst[2]  = is_jal;
         branch[0]   = is_bne;
         branch[1]   = is_beq;
         branch[2]   = is_j | is_jal;
         branch[3]   = is_jr;
         alu_op[0]   = is_addu | is_addiu | is_lw | is_sw | is_jal | is_jr;
         alu_op[1]   = is_bne | is_beq;
         alu_op[2]   = is_slt | is_slti;
         alu_op[3]   = is_sltiu;
         alu_op[6]   = is_or;
         alu_op[8]   = is_sll;
         alu_op[11]  = is_lui;
         alu_src[0]  = is_addiu | is_lw | is_sw | is_lui | is_slti | is_sltiu;
         alu_src[1]  = is_sll;
         mem_to_reg  = is_lw;
      end
   end

   // Next-state and handshake/strobe outputs; a valid holds by staying in its state.
   always_comb begin
      state_d         = state_q;
      inst_req_valid  = 1'b0;
      inst_ready      = 1'b0;
      mem_req_valid   = 1'b0;
      mem_rdata_ready = 1'b0;
      ir_write        = 1'b0;
      pc_inc          = 1'b0;
      pc_write        = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      reg_write       = 1'b0;
      write_strb      = 4'b0000;
      case (state_q)
         StInit: state_d = StIf;
         StIf: begin
            inst_req_valid = 1'b1;
            if (inst_req_ready) state_d = StIw;
         end
         StIw: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               ir_write = 1'b1;
               pc_inc   = 1'b1;
               state_d  = StId;
            end
         end
         StId: state_d = supported ? StEx : StIf;
         StEx: begin
            if (is_bne | is_beq | is_j | is_jr) begin
               pc_write = 1'b1;
               state_d  = StIf;
            end else if (is_lw | is_sw) begin
               state_d = StMem;
            end else begin
               pc_write = is_jal;
               state_d  = StWb;
            end
         end
         StMem: begin
            mem_req_valid = 1'b1;
            mem_read      = is_lw;
            mem_write     = is_sw;
            write_strb    = is_sw ? 4'b1111 : 4'b0000;
            if (mem_req_ready) state_d = is_lw ? StRdw : StIf;
         end
         StRdw: begin
            mem_rdata_ready = 1'b1;
            mem_read        = 1'b1;
            if (mem_rdata_valid) state_d = StWb;
         end
         StWb: begin
            reg_write = 1'b1;
            state_d   = StIf;
         end
         default: state_d = StInit;
      endcase
   end

   // An instruction retires whenever control returns to fetch from a later stage.
   assign retire = (state_d == StIf) && (state_q inside {StId, StEx, StMem, StWb});

   // State register and wrapping performance counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StInit;
         cycle_q <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_q + CNT_W'(1);
         if (retire) inst_q <= inst_q + CNT_W'(1);
      end
   end

   assign state     = state_q;
   assign cycle_cnt = cycle_q;
   assign inst_cnt  = inst_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed instructions push their
// per-cycle expected control trace; a negedge monitor pops and compares.
module tb_multi_cycle_control;

   localparam int KUnsup = 0, KBr = 1, KAlu = 2, KJal = 3, KLw = 4, KSw = 5;

   // Control bit positions: {irv, irdy, irw, pci, pcw, mrv, mrdy, mrd, mwr, m2r, rw}
   localparam logic [10:0] S_IRV  = 11'b100_0000_0000;
   localparam logic [10:0] S_IRDY = 11'b010_0000_0000;
   localparam logic [10:0] S_IRW  = 11'b001_0000_0000;
   localparam logic [10:0] S_PCI  = 11'b000_1000_0000;
   localparam logic [10:0] S_PCW  = 11'b000_0100_0000;
   localparam logic [10:0] S_MRV  = 11'b000_0010_0000;
   localparam logic [10:0] S_MRDY = 11'b000_0001_0000;
   localparam logic [10:0] S_MRD  = 11'b000_0000_1000;
   localparam logic [10:0] S_MWR  = 11'b000_0000_0100;
   localparam logic [10:0] S_M2R  = 11'b000_0000_0010;
   localparam logic [10:0] S_RW   = 11'b000_0000_0001;

   typedef struct packed {
      logic [3:0]  st;
      logic [10:0] ctl;
      logic [3:0]  ws;
      logic [2:0]  rd;
      logic [3:0]  br;
      logic [11:0] alu;
      logic [1:0]  src;
      logic [31:0] cyc;
      logic [31:0] ic;
   } obs_t;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      int          kind;
      logic [2:0]  rd;
      logic [3:0]  br;
      logic [11:0] alu;
      logic [1:0]  src;
      bit          m2r;
      int          ifd, iwd, rqd, rdd;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn, resetn_b;
   logic [5:0]  inst_31_26 = '0, inst_5_0 = '0;
   logic        inst_req_valid, inst_req_ready = 1'b1, inst_valid = 1'b1, inst_ready;
   logic        mem_req_valid, mem_req_ready = 1'b1, mem_rdata_valid = 1'b1, mem_rdata_ready;
   logic        ir_write, pc_inc, pc_write, mem_read, mem_write, mem_to_reg, reg_write;
   logic [2:0]  reg_dst;
   logic [3:0]  branch, write_strb, state;
   logic [11:0] alu_op;
   logic [1:0]  alu_src;
   logic [31:0] cycle_cnt, inst_cnt;

   logic [5:0]  b_op = 6'h0f;
   logic        b_irv, b_irdy, b_mrv, b_mrdy, b_irw, b_pci, b_pcw;
   logic        b_mrd, b_mwr, b_m2r, b_rw;
   logic [2:0]  b_rd;
   logic [3:0]  b_br, b_ws, b_state;
   logic [11:0] b_alu;
   logic [1:0]  b_src;
   logic [3:0]  b_cyc, b_ic;

   int          n_cmp = 0, n_fail = 0;
   bit          mon_en = 1'b0;
   int unsigned model_cyc, model_icnt;
   obs_t        exp_q[$];
   string       tag_q[$];
   logic [3:0]  in_q[$];

   always #5 clk = ~clk;

   multi_cycle_control dut (
      .clk(clk), .resetn(resetn), .inst_31_26(inst_31_26), .inst_5_0(inst_5_0),
      .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
      .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write), .reg_dst(reg_dst),
      .branch(branch), .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .write_strb(write_strb), .state(state), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
   );

   multi_cycle_control #(.CNT_W(4), .EXT_ISA(1'b0)) dut_b (
      .clk(clk), .resetn(resetn_b), .inst_31_26(b_op), .inst_5_0(6'h00),
      .inst_req_valid(b_irv), .inst_req_ready(1'b1),
      .inst_valid(1'b1), .inst_ready(b_irdy),
      .mem_req_valid(b_mrv), .mem_req_ready(1'b1),
      .mem_rdata_valid(1'b1), .mem_rdata_ready(b_mrdy),
      .ir_write(b_irw), .pc_inc(b_pci), .pc_write(b_pcw), .reg_dst(b_rd),
      .branch(b_br), .alu_op(b_alu), .alu_src(b_src), .mem_read(b_mrd),
      .mem_write(b_mwr), .mem_to_reg(b_m2r), .reg_write(b_rw),
      .write_strb(b_ws), .state(b_state), .cycle_cnt(b_cyc), .inst_cnt(b_ic)
   );

   function automatic string stname(input logic [3:0] s);
      case (s)
         4'd0: return "INIT";
         4'd1: return "IF";
         4'd2: return "IW";
         4'd3: return "ID";
         4'd4: return "EX";
         4'd5: return "MEM";
         4'd6: return "RDW";
         4'd7: return "WB";
         default: return "BAD";
      endcase
   endfunction

   function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                               input int kind, input logic [2:0] rd, input logic [3:0] br,
                               input logic [11:0] alu, input logic [1:0] src, input bit m2r,
                               input int ifd, input int iwd, input int rqd, input int rdd);
      vec_t v;
      v.name = n; v.op = op; v.fn = fn; v.kind = kind; v.rd = rd; v.br = br;
      v.alu = alu; v.src = src; v.m2r = m2r;
      v.ifd = ifd; v.iwd = iwd; v.rqd = rqd; v.rdd = rdd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   // inp = {inst_req_ready, inst_valid, mem_req_ready, mem_rdata_valid}
   task automatic add(input vec_t v, input logic [3:0] st, input logic [10:0] ctl,
                      input logic [3:0] ws, input bit dec, input logic [3:0] inp);
      obs_t e;
      e     = '0;
      e.st  = st;
      e.ctl = ctl;
      e.ws  = ws;
      e.cyc = model_cyc;
      e.ic  = model_icnt;
      if (dec) begin
         e.rd  = v.rd;
         e.br  = v.br;
         e.alu = v.alu;
         e.src = v.src;
         if (v.m2r) e.ctl = e.ctl | S_M2R;
      end
      exp_q.push_back(e);
      tag_q.push_back({v.name, ".", stname(st)});
      in_q.push_back(inp);
      model_cyc++;
   endtask

   task automatic run_vec(input vec_t v);
      logic [3:0] inp;
      in_q.delete();
      inst_31_26 = v.op;
      inst_5_0   = v.fn;
      for (int i = 0; i <= v.ifd; i++)
         add(v, 4'd1, S_IRV, 4'h0, 1'b0, (i == v.ifd) ? 4'b1111 : 4'b0111);
      for (int i = 0; i <= v.iwd; i++)
         if (i == v.iwd) add(v, 4'd2, S_IRDY | S_IRW | S_PCI, 4'h0, 1'b0, 4'b1111);
         else            add(v, 4'd2, S_IRDY, 4'h0, 1'b0, 4'b1011);
      add(v, 4'd3, '0, 4'h0, 1'b1, 4'b1111);
      case (v.kind)
         KBr: add(v, 4'd4, S_PCW, 4'h0, 1'b1, 4'b1111);
         KAlu: begin
            add(v, 4'd4, '0, 4'h0, 1'b1, 4'b1111);
            add(v, 4'd7, S_RW, 4'h0, 1'b1, 4'b1111);
         end
         KJal: begin
            add(v, 4'd4, S_PCW, 4'h0, 1'b1, 4'b1111);
            add(v, 4'd7, S_RW, 4'h0, 1'b1, 4'b1111);
         end
         KLw: begin
            add(v, 4'd4, '0, 4'h0, 1'b1, 4'b1111);
            for (int i = 0; i <= v.rqd; i++)
               add(v, 4'd5, S_MRV | S_MRD, 4'h0, 1'b1, (i == v.rqd) ? 4'b1111 : 4'b1101);
            for (int i = 0; i <= v.rdd; i++)
               add(v, 4'd6, S_MRDY | S_MRD, 4'h0, 1'b1, (i == v.rdd) ? 4'b1111 : 4'b1110);
            add(v, 4'd7, S_RW, 4'h0, 1'b1, 4'b1111);
         end
         KSw: begin
            add(v, 4'd4, '0, 4'h0, 1'b1, 4'b1111);
            for (int i = 0; i <= v.rqd; i++)
               add(v, 4'd5, S_MRV | S_MWR, 4'hf, 1'b1, (i == v.rqd) ? 4'b1111 : 4'b1101);
         end
         default: ;
      endcase
      model_icnt++;
      mon_en = 1'b1;
      while (in_q.size() > 0) begin
         inp = in_q.pop_front();
         {inst_req_ready, inst_valid, mem_req_ready, mem_rdata_valid} = inp;
         @(posedge clk);
         #1;
      end
      mon_en = 1'b0;
   endtask

   // Monitor: every monitored cycle the DUT's control outputs must match the queue head.
   always @(negedge clk) begin
      obs_t  a, e;
      string t;
      if (mon_en) begin
         a = {state, inst_req_valid, inst_ready, ir_write, pc_inc, pc_write, mem_req_valid,
              mem_rdata_ready, mem_read, mem_write, mem_to_reg, reg_write, write_strb,
              reg_dst, branch, alu_op, alu_src, cycle_cnt, inst_cnt};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_cycle: got st=%0d with no expected entry", a.st);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display({"FAIL %s: got st=%0d ctl=%b ws=%h rd=%b br=%b alu=%h src=%b cyc=%0d",
                         " ic=%0d / required st=%0d ctl=%b ws=%h rd=%b br=%b alu=%h src=%b",
                         " cyc=%0d ic=%0d"},
                        t, a.st, a.ctl, a.ws, a.rd, a.br, a.alu, a.src, a.cyc, a.ic,
                        e.st, e.ctl, e.ws, e.rd, e.br, e.alu, e.src, e.cyc, e.ic);
            end
         end
      end
   end

   function automatic logic [35:0] all_outs();
      return {inst_req_valid, inst_ready, mem_req_valid, mem_rdata_ready, ir_write, pc_inc,
              pc_write, reg_dst, branch, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
              reg_write, write_strb};
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] est;
      resetn   = 1'b1;
      resetn_b = 1'b1;
      #3;
      resetn   = 1'b0;
      resetn_b = 1'b0;
      #1;
      chk("reset_outs", 64'(all_outs()), 64'h0);
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
      chk("reset_inst_cnt", 64'(inst_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("init_state", 64'(state), 64'd0);
      model_cyc  = 1;
      model_icnt = 0;
      @(posedge clk);
      #1;

      //        name     op     fn     kind    rd      br       alu     src  m2r if iw rq rd
      run_vec(mk("ADDU",  6'h00, 6'h21, KAlu,   3'b010, 4'b0000, 12'h001, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("LW",    6'h23, 6'h00, KLw,    3'b001, 4'b0000, 12'h001, 2'b01, 1, 0, 0, 3, 2));
      run_vec(mk("SW",    6'h2b, 6'h00, KSw,    3'b000, 4'b0000, 12'h001, 2'b01, 0, 0, 0, 1, 0));
      run_vec(mk("BEQ",   6'h04, 6'h00, KBr,    3'b000, 4'b0010, 12'h002, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("JR",    6'h00, 6'h08, KBr,    3'b000, 4'b1000, 12'h001, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("JAL",   6'h03, 6'h00, KJal,   3'b100, 4'b0100, 12'h001, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("LUI",   6'h0f, 6'h00, KAlu,   3'b001, 4'b0000, 12'h800, 2'b01, 0, 0, 0, 0, 0));
      run_vec(mk("UND3F", 6'h3f, 6'h00, KUnsup, 3'b000, 4'b0000, 12'h000, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("BNE",   6'h05, 6'h00, KBr,    3'b000, 4'b0001, 12'h002, 2'b00, 0, 2, 0, 0, 0));
      run_vec(mk("J",     6'h02, 6'h00, KBr,    3'b000, 4'b0100, 12'h000, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("ADDIU", 6'h09, 6'h00, KAlu,   3'b001, 4'b0000, 12'h001, 2'b01, 0, 0, 1, 0, 0));
      run_vec(mk("SLTI",  6'h0a, 6'h00, KAlu,   3'b001, 4'b0000, 12'h004, 2'b01, 0, 0, 0, 0, 0));
      run_vec(mk("SLTIU", 6'h0b, 6'h00, KAlu,   3'b001, 4'b0000, 12'h008, 2'b01, 0, 0, 0, 0, 0));
      run_vec(mk("SLL",   6'h00, 6'h00, KAlu,   3'b010, 4'b0000, 12'h100, 2'b10, 0, 0, 0, 0, 0));
      run_vec(mk("OR",    6'h00, 6'h25, KAlu,   3'b010, 4'b0000, 12'h040, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("SLT",   6'h00, 6'h2a, KAlu,   3'b010, 4'b0000, 12'h004, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("LW0",   6'h23, 6'h00, KLw,    3'b001, 4'b0000, 12'h001, 2'b01, 1, 0, 0, 0, 0));
      run_vec(mk("RUND",  6'h00, 6'h3f, KUnsup, 3'b000, 4'b0000, 12'h000, 2'b00, 0, 0, 0, 0, 0));

      // Abandon a store mid-handshake with an asynchronous reset.
      inst_31_26 = 6'h2b;
      inst_5_0   = 6'h00;
      {inst_req_ready, inst_valid, mem_req_ready, mem_rdata_valid} = 4'b1101;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      chk("abort_mem_state", 64'(state), 64'd5);
      chk("abort_mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("abort_write_strb", 64'(write_strb), 64'hf);
      @(posedge clk);
      #1;
      chk("abort_valid_held", 64'(mem_req_valid), 64'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("abort_outs", 64'(all_outs()), 64'h0);
      chk("abort_state", 64'(state), 64'd0);
      chk("abort_cycle_cnt", 64'(cycle_cnt), 64'd0);
      chk("abort_inst_cnt", 64'(inst_cnt), 64'd0);
      @(posedge clk);
      #1;
      resetn     = 1'b1;
      {inst_req_ready, inst_valid, mem_req_ready, mem_rdata_valid} = 4'b1111;
      model_cyc  = 1;
      model_icnt = 0;
      @(posedge clk);
      #1;
      run_vec(mk("ADDU2", 6'h00, 6'h21, KAlu,   3'b010, 4'b0000, 12'h001, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("SW2",   6'h2b, 6'h00, KSw,    3'b000, 4'b0000, 12'h001, 2'b01, 0, 0, 0, 0, 0));

      // EXT_ISA=0, CNT_W=4 instance: LUI then opcode 0x3F both retire as IF/IW/ID loops.
      @(posedge clk);
      #1;
      resetn_b = 1'b1;
      for (int k = 0; k < 45; k++) begin
         #3;
         est = (k == 0) ? 4'd0 : 4'(1 + (k - 1) % 3);
         chk($sformatf("b_state_%0d", k), 64'(b_state), 64'(est));
         chk($sformatf("b_cycle_cnt_%0d", k), 64'(b_cyc), 64'(k % 16));
         chk($sformatf("b_inst_cnt_%0d", k), 64'(b_ic), 64'((k == 0) ? 0 : ((k - 1) / 3) % 16));
         chk($sformatf("b_quiet_%0d", k),
             64'({b_mrv, b_mrdy, b_pcw, b_rw, b_mwr, b_mrd, b_m2r, b_ws, b_rd, b_br, b_alu, b_src}),
             64'h0);
         @(posedge clk);
         #1;
         if (k == 20) b_op = 6'h3f;
      end

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
